digit_entry: RTL
================

# digit_entry

Front-end input stage for the digital lock. Turns the raw active-low enter button and the 4-bit digit switches into clean, one-cycle digit events: it synchronizes and debounces the button, samples the switches on each press, and flags out-of-range digits. It also tracks the position within the combination and, optionally, aborts an entry that stalls. Its outputs feed the lock FSM, which advances exactly one step per `digit_valid_o` pulse.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a button level change; minimum 1.
- `CODE_LEN`, 6: digits per combination; range 2..8.
- `TIMEOUT_CYCLES`, 1024: inter-digit timeout; used only when `DIGIT_ENTRY_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_n_i` in 1: raw enter button, asynchronous, 0 = pressed.
- `sw_i` in 4: raw digit switches, asynchronous, unsigned.
- `digit_o` out 4: digit captured at the last accepted press; held until the next press.
- `digit_valid_o` out 1: one-cycle pulse per accepted press.
- `digit_err_o` out 1: qualifies `digit_valid_o`; 1 when `digit_o` > 9.
- `last_digit_o` out 1: qualifies `digit_valid_o`; 1 when this digit is position `CODE_LEN-1`.
- `pos_o` out 3: index of the next digit to be entered, 0..CODE_LEN-1.
- `busy_o` out 1: 1 while an entry is in progress (state COLLECT).
- `abort_o` out 1: one-cycle pulse on timeout; constant 0 without the macro.

## Operation
- `key_n_i` and `sw_i` each pass through a 2-flop synchronizer. Synchronizer flops reset to key = 1 and sw = 0.
- Debounce:
  - A stable level `key_stable` resets to 1.
  - A counter increments while the synchronized key differs from `key_stable`.
  - The counter clears whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `key_stable` flips and the counter clears.
- A press event is the 1→0 transition of `key_stable`. Releases produce no event.
- On a press event, on the next edge:
  - `digit_o` ← synchronized sw.
  - `digit_valid_o` = 1.
  - `digit_err_o` = (sw > 9).
  - `last_digit_o` = (`pos_o` == CODE_LEN-1).
  - `pos_o` increments, wrapping to 0 after CODE_LEN-1.
- Error digits still consume a position. The lock FSM decides how to handle them.
- State machine (enum `entry_state_t`):
  - IDLE: `pos_o` = 0, `busy_o` = 0. A press goes to COLLECT. If CODE_LEN digits have not been entered, the FSM stays in COLLECT.
  - COLLECT: `busy_o` = 1. The press that emits `last_digit_o` returns to IDLE on the same edge.
- Reset values:
  - `digit_o` = 0.
  - All pulses/flags 0.
  - `pos_o` = 0.
  - State IDLE.
  - Debounce counter 0, `key_stable` = 1.
- Reset mid-debounce discards the partial count.
- A button held through reset is registered as one press after reset deasserts.

## Timing
- Latency: for a clean press, `key_n_i` is first sampled low at edge N. `digit_valid_o` is high in the cycle after edge N+DEBOUNCE_CYCLES+2 and is low again one edge later.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- Minimum press-to-press spacing is 2·DEBOUNCE_CYCLES + 4 cycles (press, release, press). No event is lost at that rate.
- `digit_o` is sampled from synchronized sw in the same cycle as the press event. sw changes during the debounce window are therefore irrelevant; only the value at acceptance counts.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `DIGIT_ENTRY_TIMEOUT_EN` defined:
  - A timer reloads to `TIMEOUT_CYCLES` on every press event and counts down in COLLECT.
  - Reaching 0 in COLLECT pulses `abort_o` for 1 cycle, forces `pos_o` to 0, and returns the FSM to IDLE.
  - A press event on the expiry cycle wins: no abort, the timer reloads.
  - The timer is idle in IDLE.
- Not defined: there is no timer logic, `abort_o` is tied to 0, and COLLECT persists indefinitely.

## Structure
- `lock_pkg` holds:
  - `entry_state_t` (IDLE, COLLECT).
  - `MAX_DIGIT` = 9.
  - `DEFAULT_CODE_LEN` = 6.
  - `digit_t` (logic [3:0]).
- One sub-module, `key_debounce`: it contains the synchronizer, counter and `key_stable`, and outputs a one-cycle `press_o`. The same sub-module is reused for any future buttons.
- `digit_entry` holds the sw synchronizer, capture registers, position counter, FSM and optional timer.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and CODE_LEN = 6.
- Clean press with `sw_i` = 2, key low at edge N → `digit_valid_o` high in the cycle after edge N+6, `digit_o` = 2, `digit_err_o` = 0, `pos_o` = 1, `busy_o` = 1.
- 2-cycle low glitch on `key_n_i` → no `digit_valid_o`; `pos_o` unchanged.
- Sequence 2, 8, 5, 5, 9, 1 → six pulses; `last_digit_o` = 1 only on the 6th; afterwards `pos_o` = 0 and `busy_o` = 0.
- Press with `sw_i` = 10 → `digit_valid_o` = 1, `digit_err_o` = 1, `digit_o` = 10, `pos_o` advances to 1.
- Assert `rst` after three accepted digits, with the key held low through reset → outputs return to reset values; one press with `pos_o` 0→1 is registered after `rst` deasserts.
- With `DIGIT_ENTRY_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20: one digit, then idle → `abort_o` pulses once, `pos_o` = 0, `busy_o` = 0. A second run with the press landing on the expiry cycle → no abort, `pos_o` = 2.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the digital lock front end and lock FSM.
package lock_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } entry_state_t;

    localparam int MAX_DIGIT        = 9;
    localparam int DEFAULT_CODE_LEN = 6;

    typedef logic [3:0] digit_t;

    function automatic logic digit_is_err(input digit_t d);
        return d > digit_t'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/digit_entry_key_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and press detector.
// Emits a one-cycle press_o on each accepted released->pressed transition of an active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_meta;
    logic          key_sync;
    logic          key_stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n_i;
            key_sync <= key_meta;
        end
    end

    // Any return to the stable level restarts the count, so only an unbroken run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            key_stable <= 1'b1;
            press_o    <= 1'b0;
        end else begin
            press_o <= 1'b0;
            if (key_sync == key_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                key_stable <= key_sync;
                press_o    <= ~key_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_entry.sv
// Digit entry front end: clean one-cycle digit events, position tracking and entry FSM.
// Optional inter-digit timeout is built only when DIGIT_ENTRY_TIMEOUT_EN is defined.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no entry in progress, pos_o = 0, waiting for first digit
//  COLLECT | entry in progress, more digits expected before wrap
module digit_entry
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CODE_LEN        = DEFAULT_CODE_LEN,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n_i,
    input  logic [3:0] sw_i,
    output logic [3:0] digit_o,
    output logic       digit_valid_o,
    output logic       digit_err_o,
    output logic       last_digit_o,
    output logic [2:0] pos_o,
    output logic       busy_o,
    output logic       abort_o
);

    if (DEBOUNCE_CYCLES < 1 || CODE_LEN < 2 || CODE_LEN > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("digit_entry: parameter out of range");
    end

    localparam logic [2:0] POS_LAST = 3'(CODE_LEN - 1);

    entry_state_t state;
    entry_state_t state_nxt;

    digit_t     sw_meta;
    digit_t     sw_sync;
    logic       press;
    logic       last_pos;
    logic       expire;

    digit_t     digit_q;
    logic       valid_q;
    logic       err_q;
    logic       last_q;
    logic [2:0] pos_q;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_n_i),
        .press_o (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    assign last_pos = (pos_q == POS_LAST);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;
    logic          abort_q;

    // A press on the expiry cycle reloads the timer and suppresses the abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (press) begin
            timer <= TMR_LOAD;
        end else if (state == COLLECT && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign expire = (state == COLLECT) && (timer == '0) && !press;

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= expire;
        end
    end

    assign abort_o = abort_q;
`else
    assign expire  = 1'b0;
    assign abort_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (press && last_pos) state_nxt = IDLE;
                else if (expire)       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == COLLECT);
    end

    // Error digits still consume a position; the lock FSM decides what to do with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            valid_q <= press;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            if (press) begin
                digit_q <= sw_sync;
                err_q   <= digit_is_err(sw_sync);
                last_q  <= last_pos;
                pos_q   <= last_pos ? 3'd0 : pos_q + 3'd1;
            end else if (expire) begin
                pos_q <= '0;
            end
        end
    end

    assign digit_o       = digit_q;
    assign digit_valid_o = valid_q;
    assign digit_err_o   = err_q;
    assign last_digit_o  = last_q;
    assign pos_o         = pos_q;

endmodule
